// File: rtl/grad_mag.sv
// grad_mag: two-stage pipelined saturating |gx|+|gy| with valid/ready handshake.
// Optional feature macro GRAD_MAG_THRESH_EN adds thresh_i/edge_o (registered mag >= thresh).

module add #(
  parameter int unsigned WIDTH_P = 8
) (
  input  logic [WIDTH_P-1:0] a_i,
  input  logic [WIDTH_P-1:0] b_i,
  input  logic               cin_i,
  output logic [WIDTH_P-1:0] sum_o,
  output logic               carry_o
);
  always_comb begin
    {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH_P{1'b0}}, cin_i};
  end
endmodule

module grad_mag #(
  parameter int unsigned WIDTH_P     = 11,
  parameter int unsigned OUT_WIDTH_P = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WIDTH_P-1:0]     gx_i,
  input  logic [WIDTH_P-1:0]     gy_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [OUT_WIDTH_P-1:0] mag_o,
  output logic                   sat_o,
  output logic                   valid_o,
  input  logic                   ready_i
`ifdef GRAD_MAG_THRESH_EN
  ,
  input  logic [OUT_WIDTH_P-1:0] thresh_i,
  output logic                   edge_o
`endif
);

  localparam logic [WIDTH_P:0] MAG_MAX_C = (WIDTH_P+1)'((64'd1 << OUT_WIDTH_P) - 64'd1);

  function automatic logic [WIDTH_P-1:0] abs_f(input logic [WIDTH_P-1:0] x);
    // Most-negative input wraps to 2^(WIDTH_P-1), which is the correct unsigned magnitude.
    return x[WIDTH_P-1] ? (~x + WIDTH_P'(1)) : x;
  endfunction

  logic                   s1_valid_q, s1_valid_d;
  logic [WIDTH_P-1:0]     ax_q, ax_d, ay_q, ay_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [OUT_WIDTH_P-1:0] mag_q, mag_d;
  logic                   sat_q, sat_d;
  logic                   s2_ready, s1_adv;
  logic [WIDTH_P-1:0]     sum_lo;
  logic                   sum_co;
  logic [WIDTH_P:0]       sum_full;

  add #(.WIDTH_P(WIDTH_P)) u_add (
    .a_i    (ax_q),
    .b_i    (ay_q),
    .cin_i  (1'b0),
    .sum_o  (sum_lo),
    .carry_o(sum_co)
  );

  always_comb begin
    s2_ready = !s2_valid_q || ready_i;
    s1_adv   = s1_valid_q && s2_ready;
    ready_o  = !s1_valid_q || s1_adv;
    sum_full = {sum_co, sum_lo};
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    if (ready_o) begin
      s1_valid_d = valid_i;
      if (valid_i) begin
        ax_d = abs_f(gx_i);
        ay_d = abs_f(gy_i);
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    mag_d      = mag_q;
    sat_d      = sat_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sat_d = (sum_full > MAG_MAX_C);
        mag_d = sat_d ? '1 : sum_full[OUT_WIDTH_P-1:0];
      end
    end
  end

`ifdef GRAD_MAG_THRESH_EN
  logic edge_q, edge_d;

  always_comb begin
    edge_d = edge_q;
    if (s1_adv) edge_d = (mag_d >= thresh_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) edge_q <= 1'b0;
    else         edge_q <= edge_d;
  end

  assign edge_o = edge_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      ax_q       <= '0;
      ay_q       <= '0;
      s2_valid_q <= 1'b0;
      mag_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      s2_valid_q <= s2_valid_d;
      mag_q      <= mag_d;
      sat_q      <= sat_d;
    end
  end

  assign mag_o   = mag_q;
  assign sat_o   = sat_q;
  assign valid_o = s2_valid_q;

endmodule

// File: tb/tb_grad_mag.sv
// Scoreboard bench for grad_mag: directed vectors, backpressure, random handshake, reset flush.
// Threshold checks are active when GRAD_MAG_THRESH_EN is defined.
module tb_grad_mag;
  localparam int unsigned W  = 11;
  localparam int unsigned OW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  gx_i = '0, gy_i = '0;
  logic          valid_i = 1'b0, ready_i = 1'b1;
  logic          ready_o, sat_o, valid_o;
  logic [OW-1:0] mag_o;
`ifdef GRAD_MAG_THRESH_EN
  logic [OW-1:0] thresh_i = OW'(100);
  logic          edge_o;
`endif

  grad_mag #(.WIDTH_P(W), .OUT_WIDTH_P(OW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .gx_i    (gx_i),
    .gy_i    (gy_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .mag_o   (mag_o),
    .sat_o   (sat_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef GRAD_MAG_THRESH_EN
    ,
    .thresh_i(thresh_i),
    .edge_o  (edge_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] mag;
    logic          sat;
    logic          edg;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0, cyc = 0;
  bit   lat_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [OW-1:0] m, input logic s);
    exp_t e;
    e.mag = m;
    e.sat = s;
`ifdef GRAD_MAG_THRESH_EN
    e.edg = (m >= thresh_i);
`else
    e.edg = 1'b0;
`endif
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  function automatic void model(input logic [W-1:0] gx, input logic [W-1:0] gy,
                                output logic [OW-1:0] m, output logic s);
    int sx, sy, sum;
    sx  = int'($signed(gx));
    sy  = int'($signed(gy));
    sum = (sx < 0 ? -sx : sx) + (sy < 0 ? -sy : sy);
    s   = (sum > ((1 << OW) - 1));
    m   = s ? '1 : OW'(sum);
  endfunction

  task automatic send(input logic [W-1:0] gx, input logic [W-1:0] gy,
                      input logic [OW-1:0] m, input logic s);
    int t = 0;
    bit ok = 1;
    gx_i = gx; gy_i = gy; valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      if (++t > 200) begin
        ok = 0;
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: got ready_o=0 for %0d cycles expected acceptance", t);
        break;
      end
    end
    if (ok) push_exp(m, s);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    ready_i = 1'b1;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: got %0d beats outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold-under-stall.
  initial begin
    exp_t          e;
    bit            stall_prev = 0;
    logic [OW-1:0] mag_prev = '0;
    logic          sat_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 64'(valid_o), 64'd1);
          chk("hold_mag", 64'(mag_o), 64'(mag_prev));
          chk("hold_sat", 64'(sat_o), 64'(sat_prev));
        end
        if (valid_o && ready_i) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_beat: got mag=%0d with empty scoreboard expected no beat", mag_o);
          end else begin
            e = sb.pop_front();
            chk("mag", 64'(mag_o), 64'(e.mag));
            chk("sat", 64'(sat_o), 64'(e.sat));
`ifdef GRAD_MAG_THRESH_EN
            chk("edge", 64'(edge_o), 64'(e.edg));
`endif
            if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd2);
          end
        end
        stall_prev = valid_o && !ready_i;
        mag_prev   = mag_o;
        sat_prev   = sat_o;
      end
    end
  end

  initial begin
    logic [OW-1:0] m;
    logic          s;
    logic [W-1:0]  rx, ry;
    bit            rnd_done;

    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_mag_o", 64'(mag_o), 64'd0);
    chk("rst_sat_o", 64'(sat_o), 64'd0);
`ifdef GRAD_MAG_THRESH_EN
    chk("rst_edge_o", 64'(edge_o), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one per beat, ready_i held high.
    lat_chk = 1;
    send(W'(3),     W'(-4),    OW'(7),   1'b0);
    send(W'(-1024), W'(-1024), OW'(255), 1'b1);
    send(W'(255),   W'(0),     OW'(255), 1'b0);
    send(W'(128),   W'(128),   OW'(255), 1'b1);
    send(W'(127),   W'(128),   OW'(255), 1'b0);
    send(W'(0),     W'(0),     OW'(0),   1'b0);
    send(W'(-1),    W'(1),     OW'(2),   1'b0);
    send(W'(60),    W'(-40),   OW'(100), 1'b0);
    send(W'(60),    W'(-39),   OW'(99),  1'b0);
    drain();
    lat_chk = 0;

    // Backpressure: 4 back-to-back beats, ready_i low for 4 cycles.
    ready_i = 1'b0;
    fork
      begin
        send(W'(10),   W'(1),    OW'(11),  1'b0);
        send(W'(-20),  W'(5),    OW'(25),  1'b0);
        send(W'(100),  W'(-100), OW'(200), 1'b0);
        send(W'(-300), W'(0),    OW'(255), 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_accepts", 64'(sb.size()), 64'd2);
        chk("bp_ready_o", 64'(ready_o), 64'd0);
        chk("bp_valid_o", 64'(valid_o), 64'd1);
        ready_i = 1'b1;
      end
    join
    drain();

    // Random valid_i/ready_i toggling, 1000 beats against the model.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          rx = W'($urandom);
          ry = W'($urandom);
          if (i % 50 == 0) begin rx = W'(-1024); ry = W'(1023); end
          model(rx, ry, m, s);
          send(rx, ry, m, s);
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset with two beats in flight.
    ready_i = 1'b0;
    send(W'(50), W'(50), OW'(100), 1'b0);
    send(W'(70), W'(-7), OW'(77),  1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid_o", 64'(valid_o), 64'd0);
    chk("arst_ready_o", 64'(ready_o), 64'd1);
    chk("arst_mag_o", 64'(mag_o), 64'd0);
    chk("arst_sat_o", 64'(sat_o), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_valid_o", 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    lat_chk = 1;
    send(W'(-5), W'(9), OW'(14), 1'b0);
    repeat (5) @(posedge clk);
    drain();
    chk("post_rst_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
